// File: rtl/hash_calc.sv
// hash_calc: front stage of the hash-table pipeline.
//
// Computes a bucket index for each command as a CRC-32/MPEG-2 over the key
// (poly 0x04C11DB7, non-reflected, no final XOR, key consumed MSB byte first).
// The CRC is spread over STAGES register stages; stage k folds in the k-th
// MSB-first slice of KEY_WIDTH/STAGES key bits. The stages form a
// valid/ready pipeline with bubble collapsing.
//
// Handshake: a transfer happens on a rising clk_i edge where valid && ready
// are both high. The producer holds data stable while valid is high and ready
// is low. Ready may depend combinationally on downstream ready. Valid never
// depends on ready.
//
// Flat bus layouts (MSB to LSB):
//   cmd_i       = {opcode[OPCODE_WIDTH], key[KEY_WIDTH], value[VALUE_WIDTH]}
//   pdata_out_o = {cmd, bucket[BUCKET_WIDTH], head_ptr[HEAD_PTR_WIDTH], head_ptr_val}
//   Opcodes: 0 = INIT, 1 = SEARCH, 2 = INSERT, 3 = DELETE. All are hashed the same.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cmd_i / cmd_valid_i / cmd_ready_o                 command input stream
//   pdata_out_o / pdata_out_valid_o / pdata_out_ready_i  output stream
//   busy_o                at least one stage holds a valid command
module hash_calc #(
    parameter int          KEY_WIDTH      = 32,
    parameter int          STAGES         = 2,
    parameter logic [31:0] CRC_INIT       = 32'hFFFFFFFF,
    parameter int          OPCODE_WIDTH   = 2,
    parameter int          VALUE_WIDTH    = 32,
    parameter int          BUCKET_WIDTH   = 8,
    parameter int          HEAD_PTR_WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic [OPCODE_WIDTH+KEY_WIDTH+VALUE_WIDTH-1:0] cmd_i,
    input  logic cmd_valid_i,
    output logic cmd_ready_o,
    output logic [OPCODE_WIDTH+KEY_WIDTH+VALUE_WIDTH+BUCKET_WIDTH+HEAD_PTR_WIDTH:0] pdata_out_o,
    output logic pdata_out_valid_o,
    input  logic pdata_out_ready_i,
    output logic busy_o
);

    localparam int          CMD_W   = OPCODE_WIDTH + KEY_WIDTH + VALUE_WIDTH;
    localparam int          SLICE_W = KEY_WIDTH / STAGES;
    localparam logic [31:0] POLY    = 32'h04C11DB7;

    // Fold SLICE_W data bits, MSB first, into the running CRC.
    function automatic logic [31:0] crc_slice(input logic [31:0] crc_in,
                                              input logic [SLICE_W-1:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = SLICE_W - 1; i >= 0; i--) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ POLY;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] valid_src;
    logic              all_full;

    logic [CMD_W-1:0]  cmd_q   [STAGES];
    logic [CMD_W-1:0]  cmd_src [STAGES];
    logic [31:0]       crc_q   [STAGES];
    logic [31:0]       crc_src [STAGES];
    logic [31:0]       crc_d   [STAGES];

    // adv[k] = !valid[k] || adv[k+1], unrolled: stage k may move when the
    // output is ready or any stage from k to the end is empty.
    always_comb begin
        adv      = '0;
        all_full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            adv[k]   = pdata_out_ready_i | ~all_full;
        end
    end

    assign cmd_ready_o = adv[0];

    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign cmd_src[g]   = cmd_i;
            assign crc_src[g]   = CRC_INIT;
            assign valid_src[g] = cmd_valid_i;
        end else begin : g_next
            assign cmd_src[g]   = cmd_q[g-1];
            assign crc_src[g]   = crc_q[g-1];
            assign valid_src[g] = valid_q[g-1];
        end

        assign crc_d[g]   = crc_slice(crc_src[g],
                              cmd_src[g][VALUE_WIDTH + KEY_WIDTH - 1 - g*SLICE_W -: SLICE_W]);
        // An advancing stage takes whatever is upstream, bubble included.
        assign valid_d[g] = adv[g] ? valid_src[g] : valid_q[g];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Payload registers carry no reset; valid_q qualifies them.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
                cmd_q[k] <= cmd_src[k];
                crc_q[k] <= crc_d[k];
            end
        end
    end

    assign pdata_out_o       = {cmd_q[STAGES-1], crc_q[STAGES-1][BUCKET_WIDTH-1:0],
                                {HEAD_PTR_WIDTH{1'b0}}, 1'b0};
    assign pdata_out_valid_o = valid_q[STAGES-1];
    assign busy_o            = |valid_q;

    logic unused_crc_hi;
    assign unused_crc_hi = ^crc_q[STAGES-1][31:BUCKET_WIDTH];

    cmd_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
        (cmd_valid_i && !cmd_ready_o) |=> $stable(cmd_i))
        else $warning("hash_calc: cmd_i changed while stalled");

    out_stable_a : assert property (@(posedge clk_i) disable iff (rst_i)
        (pdata_out_valid_o && !pdata_out_ready_i) |=> (pdata_out_valid_o && $stable(pdata_out_o)))
        else $error("hash_calc: pdata_out_o changed while stalled");

endmodule

// File: tb/tb_hash_calc.sv
module tb_hash_calc;

    localparam logic [1:0] OP_INIT   = 2'd0;
    localparam logic [1:0] OP_SEARCH = 2'd1;
    localparam logic [1:0] OP_INSERT = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // default-parameter instance
    logic [65:0] cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [82:0] pdata;
    logic        pdata_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    // KEY_WIDTH=72, STAGES=3 instance for the check vector
    logic [105:0] cmd72 = '0;
    logic         v72 = 1'b0;
    logic         ready72;
    logic [122:0] pdata72;
    logic         pvalid72;
    logic         r72 = 1'b1;
    logic         busy72;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [82:0] exp_q[$];
    logic [82:0] got_q[$];
    int          got_cyc_q[$];

    hash_calc u_dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_i(cmd), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .pdata_out_o(pdata), .pdata_out_valid_o(pdata_valid),
        .pdata_out_ready_i(out_ready), .busy_o(busy)
    );

    hash_calc #(.KEY_WIDTH(72), .STAGES(3)) u_dut72 (
        .clk_i(clk), .rst_i(rst),
        .cmd_i(cmd72), .cmd_valid_i(v72), .cmd_ready_o(ready72),
        .pdata_out_o(pdata72), .pdata_out_valid_o(pvalid72),
        .pdata_out_ready_i(r72), .busy_o(busy72)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // bytewise CRC-32/MPEG-2 reference over a 32-bit key
    function automatic logic [31:0] model_crc32(input logic [31:0] key);
        logic [31:0] crc;
        logic [7:0]  byte_v;
        crc = 32'hFFFFFFFF;
        for (int b = 3; b >= 0; b--) begin
            byte_v = key[b*8 +: 8];
            crc = crc ^ {byte_v, 24'h0};
            for (int j = 0; j < 8; j++)
                crc = crc[31] ? ((crc << 1) ^ 32'h04C11DB7) : (crc << 1);
        end
        return crc;
    endfunction

    function automatic logic [82:0] exp_pdata(input logic [65:0] c);
        logic [31:0] crc;
        crc = model_crc32(c[63:32]);
        return {c, crc[7:0], 8'h00, 1'b0};
    endfunction

    function automatic logic [65:0] mk_cmd(input logic [1:0] op, input logic [31:0] key,
                                           input logic [31:0] val);
        return {op, key, val};
    endfunction

    // driver: called at posedge+1, applies inputs, records handshakes, returns at next posedge+1
    task automatic step(input logic v, input logic [65:0] c, input logic r,
                        output logic in_hs, output logic out_hs);
        cmd_valid = v;
        cmd       = c;
        out_ready = r;
        #1;
        in_hs  = v && cmd_ready;
        out_hs = pdata_valid && r;
        if (in_hs) exp_q.push_back(exp_pdata(c));
        if (out_hs) begin
            got_q.push_back(pdata);
            got_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic test_reset();
        checks++; if (pdata_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", pdata_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", cmd_ready); end
        checks++; if (pvalid72 !== 1'b0 || busy72 !== 1'b0) begin errors++; $display("FAIL reset72: got valid %0b busy %0b exp 0 0", pvalid72, busy72); end
    endtask

    task automatic test_check_vector();
        logic [105:0] c72;
        logic [105:0] got_cmd;
        logic [7:0]   got_bucket;
        logic [7:0]   got_hp;
        int n;
        c72   = {OP_SEARCH, 72'h313233343536373839, 32'hCAFE0001};
        cmd72 = c72;
        v72   = 1'b1;
        r72   = 1'b0;
        #1;
        checks++; if (ready72 !== 1'b1) begin errors++; $display("FAIL cv_ready: got %0b exp 1", ready72); end
        @(posedge clk);
        #1;
        v72 = 1'b0;
        n = 1;
        while (!pvalid72 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL cv_latency: got %0d exp 3", n); end
        got_cmd    = pdata72[122:17];
        got_bucket = pdata72[16:9];
        got_hp     = pdata72[8:1];
        checks++; if (got_cmd !== c72) begin errors++; $display("FAIL cv_cmd: got %h exp %h", got_cmd, c72); end
        checks++; if (got_bucket !== 8'hE7) begin errors++; $display("FAIL cv_bucket: got %h exp e7", got_bucket); end
        checks++; if (got_hp !== 8'h00 || pdata72[0] !== 1'b0) begin errors++; $display("FAIL cv_head: got %h/%0b exp 0/0", got_hp, pdata72[0]); end
        checks++; if (u_dut72.crc_q[2] !== 32'h0376E6E7) begin errors++; $display("FAIL cv_crc: got %h exp 0376e6e7", u_dut72.crc_q[2]); end
        r72 = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (pvalid72 !== 1'b0) begin errors++; $display("FAIL cv_pop: got %0b exp 0", pvalid72); end
    endtask

    task automatic test_back_to_back();
        logic ih, oh;
        int drops;
        clear_sb();
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, mk_cmd(2'($urandom_range(0, 3)), $urandom, $urandom), 1'b1, ih, oh);
            if (!ih) drops++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, ih, oh);
        checks++; if (drops !== 0) begin errors++; $display("FAIL b2b_ready: got %0d stalls exp 0", drops); end
        checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL b2b_count: got %0d exp 16", got_q.size()); end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        if (got_cyc_q.size() == 16) begin
            checks++; if (got_cyc_q[15] - got_cyc_q[0] !== 15) begin errors++; $display("FAIL b2b_consecutive: got span %0d exp 15", got_cyc_q[15] - got_cyc_q[0]); end
        end
    endtask

    task automatic test_stall();
        logic [65:0] s [4];
        logic [82:0] held;
        logic ih, oh;
        int idx;
        clear_sb();
        s[0] = mk_cmd(OP_SEARCH, 32'h00000000, 32'h11111111);
        s[1] = mk_cmd(OP_INSERT, 32'hFFFFFFFF, 32'h22222222);
        s[2] = mk_cmd(OP_SEARCH, 32'hDEADBEEF, 32'h33333333);
        s[3] = mk_cmd(OP_INIT,   32'h80000001, 32'h44444444);
        idx = 0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s[idx], 1'b0, ih, oh);
            if (ih) idx++;
            if (i == 2) held = pdata;
        end
        checks++; if (idx !== 2) begin errors++; $display("FAIL stall_accepted: got %0d exp 2", idx); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %0b exp 0", cmd_ready); end
        checks++; if (held !== exp_pdata(s[0])) begin errors++; $display("FAIL stall_head: got %h exp %h", held, exp_pdata(s[0])); end
        checks++; if (pdata_valid !== 1'b1 || pdata !== held) begin errors++; $display("FAIL stall_hold: got %h exp %h", pdata, held); end
        step(1'b1, s[idx], 1'b1, ih, oh);
        checks++; if ({ih, oh} !== 2'b11) begin errors++; $display("FAIL stall_release: got in/out %0b%0b exp 11", ih, oh); end
        if (ih) idx++;
        for (int i = 0; i < 10 && idx < 4; i++) begin
            step(1'b1, s[idx], 1'b1, ih, oh);
            if (ih) idx++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, ih, oh);
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_pdata(s[i])) begin errors++; $display("FAIL stall_data[%0d]: got %h exp %h", i, got_q[i], exp_pdata(s[i])); end
        end
        if (got_cyc_q.size() == 4) begin
            checks++; if (got_cyc_q[3] - got_cyc_q[0] !== 3) begin errors++; $display("FAIL stall_rate: got span %0d exp 3", got_cyc_q[3] - got_cyc_q[0]); end
        end
    endtask

    task automatic test_bubble();
        logic [65:0] lst [6];
        logic ih, oh, v, r;
        int idx;
        clear_sb();
        // bubble in stage 0 filled while the output end stays stalled
        step(1'b1, mk_cmd(OP_SEARCH, 32'h01020304, 32'hA0), 1'b0, ih, oh);
        checks++; if (ih !== 1'b1) begin errors++; $display("FAIL bubble_first: got %0b exp 1", ih); end
        step(1'b0, '0, 1'b0, ih, oh);
        step(1'b1, mk_cmd(OP_INSERT, 32'h05060708, 32'hA1), 1'b0, ih, oh);
        checks++; if (ih !== 1'b1) begin errors++; $display("FAIL bubble_fill: got %0b exp 1", ih); end
        for (int i = 0; i < 6; i++) lst[i] = mk_cmd(2'(i), 32'h1000_0000 + 32'(i * 32'h01010101), 32'(i));
        idx = 0;
        step(1'b1, lst[0], 1'b0, ih, oh);
        checks++; if (ih !== 1'b0) begin errors++; $display("FAIL bubble_full: got %0b exp 0", ih); end
        // valid, idle, valid pattern against ready toggling 1,0,1,0
        for (int c = 0; c < 14; c++) begin
            v = (c % 3 != 1) && (idx < 6);
            r = (c % 2 == 0);
            step(v, lst[idx < 6 ? idx : 5], r, ih, oh);
            if (ih) idx++;
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, ih, oh);
        checks++; if (got_q.size() !== exp_q.size() || got_q.size() !== idx + 2) begin errors++; $display("FAIL bubble_count: got %0d exp %0d", got_q.size(), idx + 2); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bubble_data[%0d]: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_inflight();
        logic ih, oh;
        logic [65:0] c;
        clear_sb();
        step(1'b1, mk_cmd(OP_SEARCH, 32'hAAAA5555, 32'h1), 1'b0, ih, oh);
        step(1'b1, mk_cmd(OP_SEARCH, 32'h5555AAAA, 32'h2), 1'b0, ih, oh);
        cmd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pdata_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b exp 0", pdata_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %0b exp 0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sb();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, ih, oh);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rst_discard: got %0d outputs exp 0", got_q.size()); end
        c = mk_cmd(OP_INSERT, 32'h12345678, 32'h3);
        step(1'b1, c, 1'b1, ih, oh);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, ih, oh);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rst_next_count: got %0d exp 1", got_q.size()); end
        if (got_q.size() == 1) begin
            checks++; if (got_q[0] !== exp_pdata(c)) begin errors++; $display("FAIL rst_next_data: got %h exp %h", got_q[0], exp_pdata(c)); end
        end
    endtask

    task automatic test_opcodes();
        logic ih, oh;
        logic [65:0] c1, c2;
        logic [82:0] g0, g1;
        logic [31:0] crc;
        logic [7:0]  b_exp;
        clear_sb();
        c1 = mk_cmd(OP_INIT,   32'hC0FFEE00, 32'h5);
        c2 = mk_cmd(OP_INSERT, 32'hC0FFEE00, 32'h6);
        crc = model_crc32(32'hC0FFEE00);
        b_exp = crc[7:0];
        step(1'b1, c1, 1'b1, ih, oh);
        step(1'b1, c2, 1'b1, ih, oh);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, ih, oh);
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL op_count: got %0d exp 2", got_q.size()); end
        if (got_q.size() == 2) begin
            g0 = got_q[0];
            g1 = got_q[1];
            checks++; if (g0[82:81] !== OP_INIT) begin errors++; $display("FAIL op_init: got %0d exp %0d", g0[82:81], OP_INIT); end
            checks++; if (g1[82:81] !== OP_INSERT) begin errors++; $display("FAIL op_insert: got %0d exp %0d", g1[82:81], OP_INSERT); end
            checks++; if (g0[16:9] !== b_exp || g1[16:9] !== b_exp) begin errors++; $display("FAIL op_bucket: got %h/%h exp %h", g0[16:9], g1[16:9], b_exp); end
            checks++; if (g0 !== exp_pdata(c1) || g1 !== exp_pdata(c2)) begin errors++; $display("FAIL op_data: got %h/%h exp %h/%h", g0, g1, exp_pdata(c1), exp_pdata(c2)); end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        @(posedge clk);
        #1;
        test_check_vector();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_reset_inflight();
        test_opcodes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_calc.md
Name: hash_calc

Overview:
- Front stage of the hash-table pipeline, directly upstream of the head-table stage.
- Accepts user commands (ht_command_t), computes the bucket index as a pipelined CRC-32 over the key, and emits ht_pdata_t.
- Emitted fields: cmd copied, bucket filled, head_ptr/head_ptr_val zeroed; the head-table stage fills those from its RAM.
- Multi-stage valid/ready pipeline with bubble collapsing, so isolated downstream stalls do not drain throughput.

Parameters:
- KEY_WIDTH, 32, width of cmd.key in bits; must be a multiple of 8 and match the hash_table package.
- STAGES, 2, number of CRC pipeline stages; (KEY_WIDTH/8) must be divisible by STAGES; each stage consumes KEY_WIDTH/STAGES key bits.
- CRC_INIT, 32'hFFFFFFFF, CRC register seed.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous, active-high
- cmd_i  input  $bits(ht_command_t)  command: opcode, key, value
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  command accepted when valid && ready
- pdata_out_o  output  $bits(ht_pdata_t)  command plus bucket; head_ptr = 0, head_ptr_val = 0
- pdata_out_valid_o  output  1  output valid
- pdata_out_ready_i  input  1  downstream ready
- busy_o  output  1  one or more stages hold valid data

Behaviour:
- CRC definition:
  - CRC-32, polynomial 0x04C11DB7, non-reflected, no final XOR (CRC-32/MPEG-2).
  - Key processed MSB byte first.
  - bucket = crc[BUCKET_WIDTH-1:0].
- Pipeline structure:
  - STAGES register stages s0..s(STAGES-1).
  - Each stage holds: valid bit, full cmd, 32-bit partial CRC.
  - Stage k applies the next KEY_WIDTH/STAGES key bits (MSB-first slice k) to the CRC arriving from stage k-1; stage 0 starts from CRC_INIT.
  - All CRC logic is combinational between registers; no multicycle paths.
- Latency: exactly STAGES cycles from input handshake to pdata_out_valid_o, when unstalled.
- Throughput: one command per cycle when pdata_out_ready_i is held at 1.
- Advance rule (bubble collapsing):
  - adv[last] = !valid[last] || pdata_out_ready_i.
  - adv[k] = !valid[k] || adv[k+1].
  - cmd_ready_o = adv[0].
  - Stage k loads from stage k-1 when adv[k]. Its valid bit becomes valid[k-1] (for stage 0: cmd_valid_i && cmd_ready_o).
  - A stage that advances without new input clears its valid bit.
- Registered output fields:
  - pdata_out_o.cmd = last-stage cmd; pdata_out_o.bucket = last-stage CRC slice.
  - pdata_out_valid_o = valid[last].
  - Output is held stable while valid && !ready (AXI-stream rules). Data never changes under a pending handshake.
- Opcodes: OP_INIT passes through with bucket computed normally; it is not treated specially here. Every opcode is hashed identically.
- busy_o = OR of all stage valid bits.
- Reset:
  - All valid bits 0, so pdata_out_valid_o = 0 and busy_o = 0.
  - cmd_ready_o = 1 combinationally once out of reset.
  - Data/CRC registers need not be reset.
  - Reset mid-operation discards all in-flight commands with no output.
- Boundaries:
  - Full pipeline with pdata_out_ready_i = 0: cmd_ready_o = 0 and no stage moves.
  - Ready returning with input valid in the same cycle: output pops and input enters in that cycle (no lost cycle).
  - A bubble in a middle stage is filled while the downstream end stays stalled.
  - cmd_valid_i deasserted: no state change other than downstream drain.
- Simulation only: assertions that cmd_i is stable while cmd_valid_i && !cmd_ready_o (warning), and that pdata_out_o is stable under stall (error).

Test Plan:
- KEY_WIDTH=72, STAGES=3, BUCKET_WIDTH=8; key = 72'h313233343536373839 ("123456789"), OP_SEARCH.
  -> pdata_out_valid_o asserted exactly 3 cycles after the handshake; internal crc = 32'h0376E6E7; bucket = 8'hE7; head_ptr_val = 0; cmd copied.
- Defaults; 16 back-to-back random commands, pdata_out_ready_i = 1.
  -> cmd_ready_o stays 1; outputs appear in order on 16 consecutive cycles; buckets match the bench CRC model.
- Defaults; hold pdata_out_ready_i = 0 while driving valid.
  -> exactly 2 commands accepted, then cmd_ready_o = 0; output held stable. Release ready -> one pop per cycle and input accepted in the same cycle.
- Defaults; input pattern valid, idle, valid with ready toggling 1,0,1,0.
  -> bubble collapses; no command dropped or duplicated; scoreboard order preserved.
- Assert rst_i for 1 cycle with 2 commands in flight.
  -> pdata_out_valid_o = 0 and busy_o = 0 immediately (asynchronous); neither in-flight command ever emitted; next command after reset emitted with correct bucket.
- OP_INIT and OP_INSERT with identical keys.
  -> both emitted with identical bucket; opcodes preserved.
